// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- 8N1 UART receiver.
//
// Recovers frames of 1 start bit, 8 data bits (LSB first) and 1 stop bit from
// the asynchronous serial line and presents each good byte with a one-cycle
// strobe. The bit period is BAUD_TICKS = CLOCK_FREQ / BAUD system clocks.
// Each bit is sampled at its centre: the start bit is re-checked half a bit
// after the falling edge, and every later bit one full bit period after that.
//
// Parameters
//   CLOCK_FREQ  system clock frequency in Hz
//   BAUD        line rate in bit/s (BAUD_TICKS must be in 4..65535)
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   rx         in   asynchronous serial input, idle high
//   rx_data    out  last correctly framed byte, held until the next good frame
//   rx_valid   out  one-cycle pulse, rx_data has just been updated
//   frame_err  out  one-cycle pulse, stop bit sampled low, byte discarded
//   busy       out  high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int CLOCK_FREQ = 100000000,
    parameter int BAUD       = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int BAUD_TICKS = CLOCK_FREQ / BAUD;
    localparam int HALF       = BAUD_TICKS / 2;

    // Terminal counts for the half-bit (start centre) and full-bit intervals.
    localparam logic [15:0] HALF_LAST = 16'(HALF - 1);
    localparam logic [15:0] BIT_LAST  = 16'(BAUD_TICKS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BRK   = 3'd4
    } state_t;

    logic        sync_meta_r;
    logic        rx_s;
    state_t      state_r;
    logic [15:0] cnt_r;
    logic [2:0]  bit_idx_r;
    logic [7:0]  sr_r;

    // Two-flop synchronizer; both stages reset to the idle line level so a
    // reset never manufactures a falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta_r <= 1'b1;
            rx_s        <= 1'b1;
        end else begin
            sync_meta_r <= rx;
            rx_s        <= sync_meta_r;
        end
    end

    // Receive FSM with registered strobes and busy flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= 16'd0;
            bit_idx_r <= 3'd0;
            sr_r      <= 8'h00;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;

            case (state_r)
                IDLE: begin
                    cnt_r <= 16'd0;
                    if (!rx_s) begin
                        state_r <= START;
                        busy    <= 1'b1;
                    end else begin
                        busy    <= 1'b0;
                    end
                end

                START: begin
                    if (cnt_r == HALF_LAST) begin
                        cnt_r <= 16'd0;
                        // Still low at mid start bit: genuine frame.
                        // Otherwise it was a glitch; drop silently.
                        if (!rx_s) begin
                            state_r   <= DATA;
                            bit_idx_r <= 3'd0;
                        end else begin
                            state_r <= IDLE;
                            busy    <= 1'b0;
                        end
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end

                DATA: begin
                    if (cnt_r == BIT_LAST) begin
                        cnt_r <= 16'd0;
                        sr_r  <= {rx_s, sr_r[7:1]};
                        if (bit_idx_r == 3'd7) begin
                            state_r <= STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end

                STOP: begin
                    if (cnt_r == BIT_LAST) begin
                        cnt_r <= 16'd0;
                        if (rx_s) begin
                            // Returning to IDLE half a bit early lets a
                            // back-to-back start edge be caught on time.
                            rx_data  <= sr_r;
                            rx_valid <= 1'b1;
                            state_r  <= IDLE;
                            busy     <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            state_r   <= BRK;
                        end
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end

                BRK: begin
                    // A held-low line must not decode as repeated 0x00
                    // frames; wait for the line to return high first.
                    cnt_r <= 16'd0;
                    if (rx_s) begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end else begin
                        state_r <= BRK;
                    end
                end

                default: begin
                    state_r <= IDLE;
                    cnt_r   <= 16'd0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
